// File: rtl/rgb_to_hsv_pkg.sv
// rtl/rgb_to_hsv_pkg.sv - shared constants, beat/hue-control types and scaling helper
package rgb_to_hsv_pkg;

   localparam int LAT = 4;

   localparam logic [8:0] HUE_OFS_R = 9'd0;
   localparam logic [8:0] HUE_OFS_G = 9'd120;
   localparam logic [8:0] HUE_OFS_B = 9'd240;
   localparam logic [8:0] HUE_WRAP  = 9'd360;

   localparam logic [6:0] SCALE_H = 7'd60;
   localparam logic [6:0] SCALE_S = 7'd100;

   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;
   localparam int H_LSB = 15;
   localparam int S_LSB = 8;
   localparam int V_LSB = 0;

   // Both quotients are bounded by 100, so 7 bits always suffice.
   localparam int Q_W = 7;

   typedef struct packed {
      logic        en;
      logic [23:0] pixel;
      logic [13:0] row;
      logic [13:0] col;
      logic [23:0] pass;
   } beat_t;

   typedef struct packed {
      logic [8:0] base;
      logic       neg;
      logic       achrom;
      logic       black;
      logic [7:0] value;
   } hue_ctl_t;

   function automatic logic [14:0] scale(input logic [7:0] x, input logic [6:0] k);
      return 15'(x) * 15'(k);
   endfunction

endpackage

// File: rtl/hsv_div.sv
// rtl/hsv_div.sv - two-stage restoring divider, 15-bit dividend by 8-bit divisor
// Caller guarantees dividend < 128*divisor, so only the low Q_W quotient bits are resolved.
module hsv_div
   import rgb_to_hsv_pkg::*;
(
   input  logic           clk,
   input  logic [14:0]    dividend,
   input  logic [7:0]     divisor,
   output logic [Q_W-1:0] quotient
);

   logic [7:0] rem_a_c, rem_a, rem_b_c, div_a;
   logic [8:0] t_a, t_b;
   logic [3:0] q_a_c, q_a;
   logic [2:0] q_b_c, lo_a;

   always_comb begin
      rem_a_c = dividend[14:7];
      q_a_c   = '0;
      t_a     = '0;
      for (int i = 3; i >= 0; i--) begin
         t_a = {rem_a_c, dividend[i+3]};
         if (t_a >= {1'b0, divisor}) begin
            rem_a_c  = 8'(t_a - {1'b0, divisor});
            q_a_c[i] = 1'b1;
         end else begin
            rem_a_c = t_a[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      rem_a <= rem_a_c;
      q_a   <= q_a_c;
      lo_a  <= dividend[2:0];
      div_a <= divisor;
   end

   always_comb begin
      rem_b_c = rem_a;
      q_b_c   = '0;
      t_b     = '0;
      for (int i = 2; i >= 0; i--) begin
         t_b = {rem_b_c, lo_a[i]};
         if (t_b >= {1'b0, div_a}) begin
            rem_b_c  = 8'(t_b - {1'b0, div_a});
            q_b_c[i] = 1'b1;
         end else begin
            rem_b_c = t_b[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      quotient <= {q_a, q_b_c};
   end

endmodule

// File: rtl/rgb_to_hsv.sv
// rtl/rgb_to_hsv.sv - fixed-latency RGB to HSV pixel converter with per-beat bypass
module rgb_to_hsv
   import rgb_to_hsv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsv_en,
   input  logic        in_valid,
   input  logic [23:0] pixel_in,
   input  logic [13:0] row_in,
   input  logic [13:0] col_in,
   input  logic [23:0] pass_in,
   output logic        out_valid,
   output logic [23:0] pixel_out,
   output logic [13:0] row_out,
   output logic [13:0] col_out,
   output logic [23:0] pass_thru
);

   logic [LAT-1:0] vld;
   beat_t          beat [LAT];
   hue_ctl_t       ctl_c, ctl_1, ctl_2;
   logic [7:0]     r, g, b, mn, diff, delta;
   logic [14:0]    dvd_h, dvd_s;
   logic [Q_W-1:0] q_h, q_s;
   logic [8:0]     hue_sum, hue;
   logic [23:0]    hsv_c;

   assign r = beat[0].pixel[R_LSB +: 8];
   assign g = beat[0].pixel[G_LSB +: 8];
   assign b = beat[0].pixel[B_LSB +: 8];

   // Max channel picks the hue sector; ties resolve R, then G, then B.
   always_comb begin
      ctl_c = '0;
      mn    = '0;
      diff  = '0;
      delta = '0;
      if (r >= g && r >= b) begin
         ctl_c.value = r;
         mn          = (g < b) ? g : b;
         ctl_c.base  = HUE_OFS_R;
         if (g >= b) begin
            diff = g - b;
         end else begin
            diff       = b - g;
            ctl_c.neg  = 1'b1;
            ctl_c.base = HUE_WRAP;
         end
      end else if (g >= b) begin
         ctl_c.value = g;
         mn          = (r < b) ? r : b;
         ctl_c.base  = HUE_OFS_G;
         if (b >= r) begin
            diff = b - r;
         end else begin
            diff      = r - b;
            ctl_c.neg = 1'b1;
         end
      end else begin
         ctl_c.value = b;
         mn          = (r < g) ? r : g;
         ctl_c.base  = HUE_OFS_B;
         if (r >= g) begin
            diff = r - g;
         end else begin
            diff      = g - r;
            ctl_c.neg = 1'b1;
         end
      end
      delta        = ctl_c.value - mn;
      ctl_c.achrom = (delta == 8'd0);
      ctl_c.black  = (ctl_c.value == 8'd0);
   end

   assign dvd_h = scale(diff, SCALE_H);
   assign dvd_s = scale(delta, SCALE_S);

   hsv_div u_div_hue (.clk(clk), .dividend(dvd_h), .divisor(delta),       .quotient(q_h));
   hsv_div u_div_sat (.clk(clk), .dividend(dvd_s), .divisor(ctl_c.value), .quotient(q_s));

   // Zero divisors yield junk quotients; the achrom/black flags mask them here.
   always_comb begin
      hue_sum = ctl_2.neg ? (ctl_2.base - 9'(q_h)) : (ctl_2.base + 9'(q_h));
      hue     = (ctl_2.achrom || hue_sum == HUE_WRAP) ? 9'd0 : hue_sum;
      hsv_c   = '0;
      hsv_c[H_LSB +: 9] = hue;
      hsv_c[S_LSB +: 7] = ctl_2.black ? 7'd0 : q_s;
      hsv_c[V_LSB +: 8] = ctl_2.value;
   end

   always_ff @(posedge clk) begin
      beat[0] <= '{en: hsv_en, pixel: pixel_in, row: row_in, col: col_in, pass: pass_in};
      beat[1] <= beat[0];
      beat[2] <= beat[1];
      beat[3] <= '{en: beat[2].en, pixel: (beat[2].en ? hsv_c : beat[2].pixel),
                   row: beat[2].row, col: beat[2].col, pass: beat[2].pass};
      ctl_1   <= ctl_c;
      ctl_2   <= ctl_1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld       <= '0;
         out_valid <= 1'b0;
         pixel_out <= '0;
         row_out   <= '0;
         col_out   <= '0;
         pass_thru <= '0;
      end else begin
         vld       <= {vld[LAT-2:0], in_valid};
         out_valid <= vld[LAT-1];
         pixel_out <= beat[LAT-1].pixel;
         row_out   <= beat[LAT-1].row;
         col_out   <= beat[LAT-1].col;
         pass_thru <= beat[LAT-1].pass;
      end
   end

endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb/tb_rgb_to_hsv.sv - randomized and directed self-checking bench for rgb_to_hsv
module tb_rgb_to_hsv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsv_en;
   logic        in_valid;
   logic [23:0] pixel_in;
   logic [13:0] row_in;
   logic [13:0] col_in;
   logic [23:0] pass_in;
   logic        out_valid;
   logic [23:0] pixel_out;
   logic [13:0] row_out;
   logic [13:0] col_out;
   logic [23:0] pass_thru;

   typedef struct {
      int          due;
      logic [23:0] pix;
      logic [13:0] row;
      logic [13:0] col;
      logic [23:0] pass;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] cur_exp;
   int          edge_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   rgb_to_hsv dut (
      .clk(clk), .rst_n(rst_n), .hsv_en(hsv_en), .in_valid(in_valid),
      .pixel_in(pixel_in), .row_in(row_in), .col_in(col_in), .pass_in(pass_in),
      .out_valid(out_valid), .pixel_out(pixel_out), .row_out(row_out),
      .col_out(col_out), .pass_thru(pass_thru)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, edge_n);
      end
   endtask

   function automatic logic [23:0] ref_hsv(input logic [23:0] p);
      int r, g, b, mx, mn, d, h, s;
      r  = int'(p[23:16]);
      g  = int'(p[15:8]);
      b  = int'(p[7:0]);
      mx = (r > g) ? r : g;
      mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g;
      mn = (mn < b) ? mn : b;
      d  = mx - mn;
      s  = (mx == 0) ? 0 : (100 * d) / mx;
      if (d == 0)       h = 0;
      else if (r == mx) h = (g >= b) ? (60 * (g - b)) / d : 360 - (60 * (b - g)) / d;
      else if (g == mx) h = (b >= r) ? 120 + (60 * (b - r)) / d : 120 - (60 * (r - b)) / d;
      else              h = (r >= g) ? 240 + (60 * (r - g)) / d : 240 - (60 * (g - r)) / d;
      if (h == 360) h = 0;
      return {9'(h), 7'(s), 8'(mx)};
   endfunction

   function automatic logic [7:0] rand_chan();
      case ($urandom_range(0, 3))
         0:       return 8'd0;
         1:       return 8'd255;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [23:0] rand_pix();
      logic [7:0] a;
      a = rand_chan();
      case ($urandom_range(0, 4))
         0:       return {a, a, a};
         1:       return {a, a, rand_chan()};
         2:       return {rand_chan(), a, a};
         default: return {rand_chan(), rand_chan(), rand_chan()};
      endcase
   endfunction

   task automatic check_outputs();
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
         check_eq("out_valid", 32'(out_valid), 32'd1);
         check_eq("pixel_out", 32'(pixel_out), 32'(exp_q[0].pix));
         check_eq("row_out",   32'(row_out),   32'(exp_q[0].row));
         check_eq("col_out",   32'(col_out),   32'(exp_q[0].col));
         check_eq("pass_thru", 32'(pass_thru), 32'(exp_q[0].pass));
         void'(exp_q.pop_front());
      end else begin
         check_eq("out_valid_idle", 32'(out_valid), 32'd0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      if (rst_n && in_valid)
         exp_q.push_back('{due: edge_n + 4, pix: cur_exp, row: row_in, col: col_in, pass: pass_in});
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic en, input logic [23:0] pix, input logic [23:0] want);
      in_valid = v;
      hsv_en   = en;
      pixel_in = pix;
      row_in   = 14'($urandom);
      col_in   = 14'($urandom);
      pass_in  = 24'($urandom);
      cur_exp  = want;
      step();
   endtask

   task automatic beat_rand(input logic v, input logic en);
      logic [23:0] p;
      p = rand_pix();
      drive(v, en, p, en ? ref_hsv(p) : p);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat_rand(1'b0, 1'($urandom));
   endtask

   initial begin
      rst_n    = 1'b0;
      hsv_en   = 1'b0;
      in_valid = 1'b0;
      pixel_in = '0;
      row_in   = '0;
      col_in   = '0;
      pass_in  = '0;
      cur_exp  = '0;
      #2;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_pixel_out", 32'(pixel_out), 32'd0);
      check_eq("rst_row_out",   32'(row_out),   32'd0);
      check_eq("rst_col_out",   32'(col_out),   32'd0);
      check_eq("rst_pass_thru", 32'(pass_thru), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      drive(1'b1, 1'b1, 24'hFF0000, 24'h0064FF); idle(5);
      drive(1'b1, 1'b1, 24'h00FF00, 24'h3C64FF); idle(5);
      drive(1'b1, 1'b1, 24'h0000FF, 24'h7864FF); idle(5);
      drive(1'b1, 1'b1, 24'h808080, 24'h000080); idle(5);
      drive(1'b1, 1'b1, 24'h000000, 24'h000000); idle(5);
      drive(1'b1, 1'b1, 24'hFF0001, 24'h0064FF); idle(5);

      for (int i = 0; i < 8; i++) beat_rand(1'b1, 1'(~i[0]));
      idle(6);

      for (int i = 0; i < 400; i++) beat_rand(1'($urandom_range(0, 3) != 0), 1'($urandom));
      idle(6);

      idle(3);
      for (int i = 0; i < 3; i++) beat_rand(1'b1, 1'($urandom));
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_pixel_out", 32'(pixel_out), 32'd0);
      check_eq("mid_rst_row_out",   32'(row_out),   32'd0);
      check_eq("mid_rst_col_out",   32'(col_out),   32'd0);
      check_eq("mid_rst_pass_thru", 32'(pass_thru), 32'd0);
      exp_q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(6);
      beat_rand(1'b1, 1'b1);
      idle(6);

      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
